log2_ctrl: RTL

Sequencer and two-port arbiter for the shared `log2` datapath in the calculator. Two requesters (e.g. the keypad op path and the chained-expression path) submit 16-bit operands. The controller:
- screens operands the datapath cannot handle;
- drives the unit's `log2_rst` / `log2_start` pulses for exactly the required iteration count;
- captures the 32-bit fixed-point result and returns it on a valid/ready response port tagged with the requester ID.

---
 rtl/log2_ctrl_pkg.sv | 8 +
 rtl/log2_ctrl_if.sv | 22 ++
 rtl/log2_ctrl_rr_arb2.sv | 21 ++
 rtl/log2_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/log2_ctrl_pkg.sv
// log2_ctrl_pkg: shared types and constants for the log2 sequencer
package log2_ctrl_pkg;
   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_RESP} state_e;
   typedef enum logic [1:0] {ERR_OK = 2'b00, ERR_ZERO = 2'b01, ERR_RANGE = 2'b10, ERR_TIMEOUT = 2'b11} err_e;
   localparam int LOG2_RUN_CYCLES = 22;
   localparam int MAX_OPERAND_DEF = 1023;
   localparam int TIMEOUT_DEF     = 31;
endpackage

// File: rtl/log2_ctrl_if.sv
// log2_ctrl_if: two request ports and the response port of the log2 controller
interface log2_ctrl_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [15:0] req0_operand;
   logic        req1_valid;
   logic        req1_ready;
   logic [15:0] req1_operand;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_result;
   logic [1:0]  rsp_err;
   modport master (
      output req0_valid, req0_operand, req1_valid, req1_operand, rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_err
   );
   modport slave (
      input  req0_valid, req0_operand, req1_valid, req1_operand, rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_err
   );
endinterface

// File: rtl/log2_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the pointer moves only when a grant is accepted
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);
   logic last_q, last_d;
   // grant favours whichever requester did not win last time
   always_comb begin
      gnt[0] = en && req[0] && (!req[1] || last_q);
      gnt[1] = en && req[1] && (!req[0] || !last_q);
      last_d = accept ? gnt[1] : last_q;
   end
   // last-winner register; reset value makes req0 the favoured requester
   always_ff @(posedge clk) begin
      last_q <= !rst ? 1'b1 : last_d;
   end
endmodule

// File: rtl/log2_ctrl.sv
// log2_ctrl: arbitrates two requesters onto the shared log2 datapath and sequences it
module log2_ctrl
   import log2_ctrl_pkg::*;
#(
   parameter int TIMEOUT     = TIMEOUT_DEF,
   parameter int MAX_OPERAND = MAX_OPERAND_DEF
) (
   input  logic        clk,
   input  logic        rst,
   log2_ctrl_if.slave  bus,
   output logic [15:0] log2_input,
   output logic        log2_rst,
   output logic        log2_start,
   input  logic [31:0] log2_result,
   input  logic        log2_done,
   output logic        busy
);
   localparam int             WDW     = $clog2(TIMEOUT + 1);
   localparam logic [15:0]    MAX_OP  = 16'(MAX_OPERAND);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

   state_e         state_q, state_d;
   err_e           err_q, err_d;
   logic [15:0]    input_q, input_d;
   logic [31:0]    result_q, result_d;
   logic           id_q, id_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic [1:0]     gnt;
   logic           accept;
   logic [15:0]    sel_op;
   logic           screen_ok;
   logic           wd_expired;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .en     (rst && state_q == S_IDLE),
      .req    ({bus.req1_valid, bus.req0_valid}),
      .accept (accept),
      .gnt    (gnt)
   );

   assign accept     = |gnt;
   assign sel_op     = gnt[1] ? bus.req1_operand : bus.req0_operand;
   assign screen_ok  = sel_op > 16'd1 && sel_op <= MAX_OP;
   assign wd_expired = wd_q == WD_LAST;

   // state, operand, id, result, error and watchdog registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         err_q    <= ERR_OK;
         input_q  <= '0;
         result_q <= '0;
         id_q     <= 1'b0;
         wd_q     <= '0;
      end else begin
         state_q  <= state_d;
         err_q    <= err_d;
         input_q  <= input_d;
         result_q <= result_d;
         id_q     <= id_d;
         wd_q     <= wd_d;
      end
   end

   // next state: screen on accept, one clear cycle, run until done or watchdog, hold response
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = !accept ? S_IDLE : screen_ok ? S_CLEAR : S_RESP;
         S_CLEAR: state_d = S_RUN;
         S_RUN:   state_d = (log2_done || wd_expired) ? S_RESP : S_RUN;
         S_RESP:  state_d = bus.rsp_ready ? S_IDLE : S_RESP;
         default: state_d = S_IDLE;
      endcase
   end

   // datapath-side register updates; done takes priority over a coincident watchdog expiry
   always_comb begin
      input_d  = accept ? sel_op : input_q;
      id_d     = accept ? gnt[1] : id_q;
      wd_d     = state_q == S_CLEAR ? '0 : state_q == S_RUN ? wd_q + WDW'(1) : wd_q;
      result_d = result_q;
      err_d    = err_q;
      if (accept) begin
         result_d = '0;
         err_d    = sel_op == 16'd0 ? ERR_ZERO : sel_op > MAX_OP ? ERR_RANGE : ERR_OK;
      end else if (state_q == S_RUN && log2_done) begin
         result_d = log2_result;
         err_d    = ERR_OK;
      end else if (state_q == S_RUN && wd_expired) begin
         result_d = '0;
         err_d    = ERR_TIMEOUT;
      end
   end

   // outputs decoded from state; start drops on done so the datapath counter parks at its final value
   always_comb begin
      log2_rst       = state_q == S_CLEAR;
      log2_start     = state_q == S_RUN && !log2_done && !wd_expired;
      busy           = state_q != S_IDLE;
      bus.rsp_valid  = state_q == S_RESP;
      bus.rsp_id     = id_q;
      bus.rsp_result = result_q;
      bus.rsp_err    = err_q;
      bus.req0_ready = gnt[0];
      bus.req1_ready = gnt[1];
      log2_input     = input_q;
   end
endmodule
